// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame check, timeout.
// Optional break-code suppression is built when PS2_BREAK_FILTER_EN is defined.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       enable,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    FLT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_clk_f;
    logic          r_clk_fq;
    logic [7:0]    r_flt_cnt;
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_scancode;
    logic          r_enable;
    logic          r_frame_err;
`ifdef PS2_BREAK_FILTER_EN
    logic          r_brk;
`endif

    logic w_fall;
    logic w_data;
    logic w_frame_ok;

    assign w_fall     = r_clk_fq & ~r_clk_f;
    assign w_data     = r_dat_s2;
    assign w_frame_ok = w_data & (^{r_shreg, r_par});

    // Two-flop synchronisers; idle-high pins reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows the pin only after FILTER_LEN disagreeing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_f   <= 1'b1;
            r_clk_fq  <= 1'b1;
            r_flt_cnt <= 8'd0;
        end else begin
            r_clk_fq <= r_clk_f;
            if (r_clk_s2 != r_clk_f) begin
                if (r_flt_cnt == FLT_LAST) begin
                    r_clk_f   <= r_clk_s2;
                    r_flt_cnt <= 8'd0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 8'd1;
                end
            end else begin
                r_flt_cnt <= 8'd0;
            end
        end
    end

    // Frame FSM with timeout; a fall always beats a same-cycle timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shreg     <= 8'd0;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_scancode  <= 8'd0;
            r_enable    <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            r_brk       <= 1'b0;
`endif
        end else begin
            r_enable    <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                unique case (r_state)
                    S_IDLE: begin
                        if (!w_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        r_shreg   <= {w_data, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= w_data;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (w_frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (r_shreg == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else if (r_brk) begin
                                r_brk <= 1'b0;
                            end else begin
                                r_scancode <= r_shreg;
                                r_enable   <= 1'b1;
                            end
`else
                            r_scancode <= r_shreg;
                            r_enable   <= 1'b1;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            r_brk       <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TO_LAST) begin
                // The increment that would reach TIMEOUT_CYCLES aborts the frame.
                r_state     <= S_IDLE;
                r_to_cnt    <= '0;
                r_bit_cnt   <= 3'd0;
                r_shreg     <= 8'd0;
                r_frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                r_brk       <= 1'b0;
`endif
            end else begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end
        end
    end

    assign scancode  = r_scancode;
    assign enable    = r_enable;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: frame table plus scoreboard monitor.
// Break-sequence expectations follow PS2_BREAK_FILTER_EN.
module tb_ps2_scan_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int H  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       enable;
    logic       frame_err;

    ps2_scan_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .scancode (scancode),
        .enable   (enable),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ok;
        logic [7:0] code;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        bit         flip_par;
        bit         bad_stop;
        bit         ok;
    } vec_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fall = 0;
    logic [7:0] model_code = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d,
                                            input bit fp, input bit bs);
        return {~bs, (~^d) ^ fp, d, 1'b0};
    endfunction

    task automatic expect_frame(input bit ok, input logic [7:0] d,
                                input int lat);
        exp_t e;
        if (ok) model_code = d;
        e.ok   = ok;
        e.code = model_code;
        e.lat  = lat;
        q.push_back(e);
    endtask

    // Drives n bits of a frame; optional low glitch in the high phase.
    task automatic send_bits(input logic [10:0] bits, input int n,
                             input int glen, input int gpos);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wcyc(H / 2);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wcyc(H);
            ps2_clk = 1'b1;
            wcyc(12);
            if (glen > 0 && (gpos < 0 || gpos == i)) begin
                ps2_clk = 1'b0;
                wcyc(glen);
                ps2_clk = 1'b1;
            end
            wcyc(10);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        wcyc(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d strobes missing, expected 0", nm, q.size());
            q.delete();
        end
    endtask

    // Scoreboard monitor: every strobe pops one expectation.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (enable || frame_err) begin
                    chk("exclusive", {31'd0, enable & frame_err}, 32'd0);
                    chk("width", {31'd0, prev}, 32'd0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected: enable=%0b frame_err=%0b code=%0h expected none",
                                 enable, frame_err, scancode);
                    end else begin
                        e = q.pop_front();
                        chk("kind", {31'd0, enable}, {31'd0, e.ok});
                        chk("code", {24'd0, scancode}, {24'd0, e.code});
                        if (e.lat > 0)
                            chk("latency", cyc - last_fall, e.lat);
                    end
                end
                prev = enable | frame_err;
            end
        end
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{8'h2B, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h15, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h33, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        wcyc(3);
        chk("rst_code", {24'd0, scancode}, 32'd0);
        chk("rst_en", {31'd0, enable}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wcyc(20);

        for (int i = 0; i < 7; i++) begin
            expect_frame(tbl[i].ok, tbl[i].d, FL + 3);
            send_bits(mkframe(tbl[i].d, tbl[i].flip_par, tbl[i].bad_stop),
                      11, 0, 0);
            drain("table");
        end

        expect_frame(1'b1, 8'h22, FL + 3);
        send_bits(mkframe(8'h22, 1'b0, 1'b0), 11, FL - 1, -1);
        drain("glitch_short");

        expect_frame(1'b0, 8'h22, 0);
        send_bits(mkframe(8'h22, 1'b0, 1'b0), 11, FL, 3);
        drain("glitch_long");

        expect_frame(1'b0, 8'h00, FL + 3 + TO);
        send_bits(mkframe(8'h5A, 1'b0, 1'b0), 5, 0, 0);
        drain("timeout");
        expect_frame(1'b1, 8'h2B, FL + 3);
        send_bits(mkframe(8'h2B, 1'b0, 1'b0), 11, 0, 0);
        drain("after_timeout");

`ifdef PS2_BREAK_FILTER_EN
        send_bits(mkframe(8'hF0, 1'b0, 1'b0), 11, 0, 0);
        send_bits(mkframe(8'h2B, 1'b0, 1'b0), 11, 0, 0);
        drain("break");
        chk("break_hold", {24'd0, scancode}, {24'd0, model_code});
        expect_frame(1'b1, 8'h15, FL + 3);
        send_bits(mkframe(8'h15, 1'b0, 1'b0), 11, 0, 0);
        drain("after_break");
`else
        expect_frame(1'b1, 8'hF0, FL + 3);
        send_bits(mkframe(8'hF0, 1'b0, 1'b0), 11, 0, 0);
        expect_frame(1'b1, 8'h2B, FL + 3);
        send_bits(mkframe(8'h2B, 1'b0, 1'b0), 11, 0, 0);
        drain("break");
        chk("break_final", {24'd0, scancode}, 32'h2B);
`endif

        send_bits(mkframe(8'h6C, 1'b0, 1'b0), 6, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_code", {24'd0, scancode}, 32'd0);
        chk("mid_rst_en", {31'd0, enable}, 32'd0);
        chk("mid_rst_err", {31'd0, frame_err}, 32'd0);
        model_code = 8'h00;
        wcyc(5);
        reset = 1'b0;
        wcyc(20);
        expect_frame(1'b1, 8'h33, FL + 3);
        send_bits(mkframe(8'h33, 1'b0, 1'b0), 11, 0, 0);
        drain("after_reset");
        chk("final_code", {24'd0, scancode}, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 keyboard receiver that deserialises device-to-host frames from the raw `ps2_clk`/`ps2_data` pins and delivers each validated byte as an 8-bit scancode with a one-cycle `enable` strobe. It sits directly upstream of the character/servo register stage, which latches `scancode` when `enable` is high. It also provides pin synchronisation, glitch filtering, parity/stop checking, frame timeout and optional break-code suppression.

## Interface
- `FILTER_LEN`, 8: consecutive stable `clk` cycles required before the filtered PS/2 clock changes level (1..255).
- `TIMEOUT_CYCLES`, 50000: maximum `clk` cycles between filtered falling edges inside a frame (1 ms at 50 MHz).
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `scancode` output 8: last accepted byte; holds its value between frames.
- `enable` output 1: one-cycle strobe; `scancode` is valid in the same cycle.
- `frame_err` output 1: one-cycle strobe on a parity, start, stop or timeout error.

## Operation
- **Synchronisation:** both pins pass through 2-flop synchronisers.
- **Clock filtering:** `clk_f` resets to 1. It takes the synchronised `ps2_clk` value only after that value has differed from `clk_f` for `FILTER_LEN` consecutive cycles. Any mismatch shorter than that clears the filter counter.
- **Edge detection:** a falling edge of `clk_f` produces a one-cycle `fall` pulse. Data is sampled from synchronised `ps2_data` in the `fall` cycle.
- **Frame format:** 11 bits — start (0), 8 data bits LSB first, odd parity, stop (1).
- **State machine:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 → DATA, bit count cleared. A `fall` with data=1 is ignored and the state stays IDLE (no error).
  - DATA: on each `fall`, shift the bit into `shreg[7]` (right shift). After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: on `fall`, the frame is valid iff stop=1 and XOR(data, parity)=1. Valid → update `scancode`, pulse `enable`. Invalid → pulse `frame_err`, `scancode` unchanged. Either way → IDLE.
- **Timeout:** the counter clears on every `fall` and in IDLE, and increments in the other states. Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err` and discards partial data.
- **Simultaneous events:** if the timeout and a `fall` occur in the same cycle, the `fall` wins and the counter clears.
- **Error exclusivity:** `enable` and `frame_err` are never high together.
- **Reset (any time, including mid-frame):** `scancode`=0x00, `enable`=0, `frame_err`=0, state IDLE, `clk_f`=1, all counters 0, shift register 0.

## Timing
- **Filtered edge latency:** a filtered falling edge is detected exactly 2 + `FILTER_LEN` cycles after the physical `ps2_clk` fall, given a stable pin.
- **Output latency:** `enable`/`frame_err` are registered and assert one cycle after the stop-bit `fall`, i.e. `FILTER_LEN`+3 cycles after the physical edge.
- **Pulse width:** both strobes are exactly one cycle wide. Back-to-back frames produce separate strobes; at least 11 `fall` events separate them.
- **Data setup:** `ps2_data` must be stable for at least 2 cycles before the physical `ps2_clk` fall. This is met by the PS/2 specification at any `clk` ≥ 1 MHz.
- **Widths:** bit counter 3 bits; filter counter 8 bits; timeout counter $clog2(`TIMEOUT_CYCLES`+1) bits, saturating.

## Configuration
- `PS2_BREAK_FILTER_EN` defined:
  - A valid 0xF0 byte sets an internal `brk` flag and produces no `enable`.
  - The next valid byte clears `brk` and is also suppressed (no `enable`, `scancode` unchanged).
  - `frame_err` and `reset` also clear `brk`.
  - Only make codes reach downstream.
- `PS2_BREAK_FILTER_EN` undefined: every valid byte, including 0xF0 and 0xE0, updates `scancode` and strobes `enable`. No `brk` logic is present.

## Test plan
- **Valid frame:** 0x2B with correct odd parity (parity=1) at a 12 kHz PS/2 clock → `scancode`=0x2B, `enable` high exactly 1 cycle, `FILTER_LEN`+3 cycles after the stop-bit fall; `frame_err` stays 0.
- **Parity error:** 0x15 with parity=1 (wrong) → `frame_err` 1-cycle pulse, no `enable`, `scancode` holds its previous 0x2B. A following good 0x33 → `scancode`=0x33.
- **Glitch rejection:** `ps2_clk` low glitches of `FILTER_LEN`-1 cycles injected between bits of 0x22 → ignored, `scancode`=0x22. A glitch of `FILTER_LEN` cycles → counted as an edge, frame misaligns, `frame_err` pulses or a timeout occurs.
- **Timeout:** clock stops after 4 data bits → `frame_err` pulse exactly `TIMEOUT_CYCLES` cycles after the last `fall`, state IDLE. A subsequent 0x2B is received correctly.
- **Break sequence:** F0 then 2B.
  - Macro defined → zero `enable` pulses, `scancode` unchanged; a following 0x15 → `enable`, `scancode`=0x15.
  - Macro undefined → two `enable` pulses, final `scancode`=0x2B.
- **Reset mid-frame:** `reset` asserted after 5 data bits → outputs 0 immediately (asynchronously). After release, a full 0x33 frame → `scancode`=0x33 with one `enable`.
